// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - channel state type and select-width rule for multi_tick_timer
package timer_pkg;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_t;

   localparam int MIN_SEL_W = 1;

   // A single channel still gets a one-bit cfg_ch port.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : MIN_SEL_W;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one tick channel: shadow/active period, counter, pulse and done flags
// AUTO_START_EN: channel leaves reset running periodically at DEFAULT_PERIOD.
module timer_channel
   import timer_pkg::*;
#(
   parameter int     CNT_W          = 32,
   parameter longint DEFAULT_PERIOD = 100_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic             cfg_oneshot,
   input  logic             start,
   input  logic             stop,
   output logic             pulse,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
`ifdef AUTO_START_EN
   localparam ch_state_t RST_STATE = CH_RUN;
`else
   localparam ch_state_t RST_STATE = CH_IDLE;
`endif

   ch_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_period_q, act_period_d;
   logic             act_oneshot_q, act_oneshot_d;
   logic [CNT_W-1:0] shadow_period_q;
   logic             shadow_oneshot_q;
   logic             pulse_q, pulse_d;
   logic             done_q, done_d;
   logic             last;

   assign last = (cnt_q == act_period_q - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= RST_STATE;
         cnt_q            <= '0;
         act_period_q     <= DEF_P;
         act_oneshot_q    <= 1'b0;
         shadow_period_q  <= DEF_P;
         shadow_oneshot_q <= 1'b0;
         pulse_q          <= 1'b0;
         done_q           <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         act_period_q  <= act_period_d;
         act_oneshot_q <= act_oneshot_d;
         pulse_q       <= pulse_d;
         done_q        <= done_d;
         if (cfg_we) begin
            shadow_period_q  <= cfg_period;
            shadow_oneshot_q <= cfg_oneshot;
         end
      end
   end

   // Stop beats start beats expiry; a start against a zero shadow falls through.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      act_period_d  = act_period_q;
      act_oneshot_d = act_oneshot_q;
      pulse_d       = 1'b0;
      done_d        = done_q;
      if (stop) begin
         state_d = CH_IDLE;
         cnt_d   = '0;
         done_d  = 1'b0;
      end else if (start && (shadow_period_q != '0)) begin
         state_d       = CH_RUN;
         cnt_d         = '0;
         act_period_d  = shadow_period_q;
         act_oneshot_d = shadow_oneshot_q;
         done_d        = 1'b0;
      end else if ((state_q == CH_RUN) && tick) begin
         if (last) begin
            pulse_d = 1'b1;
            cnt_d   = '0;
            if (act_oneshot_q) begin
               state_d = CH_IDLE;
               done_d  = 1'b1;
            end else begin
               act_period_d  = shadow_period_q;
               act_oneshot_d = shadow_oneshot_q;
               if (shadow_period_q == '0)
                  state_d = CH_IDLE;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign pulse = pulse_q;
   assign busy  = (state_q == CH_RUN);
   assign done  = done_q;

endmodule

// File: rtl/multi_tick_timer.sv
// rtl/multi_tick_timer.sv - NUM_CH tick channels sharing one prescaler
// AUTO_START_EN: every channel free-runs at DEFAULT_PERIOD straight out of reset.
module multi_tick_timer
   import timer_pkg::*;
#(
   parameter int     NUM_CH         = 4,
   parameter int     CNT_W          = 32,
   parameter int     PRESCALE       = 1,
   parameter longint DEFAULT_PERIOD = 100_000_000,
   localparam int    CH_W           = sel_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic              cfg_oneshot,
   input  logic [NUM_CH-1:0] start,
   input  logic [NUM_CH-1:0] stop,
   output logic [NUM_CH-1:0] pulse,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] done
);

   localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0]   ps_q;
   logic              tick;
   logic [NUM_CH-1:0] ch_we;

   // With PRESCALE=1 the count sits at zero and tick stays high.
   assign tick = (ps_q == PS_LAST);

   always_ff @(posedge clk) begin
      if (rst || tick)
         ps_q <= '0;
      else
         ps_q <= ps_q + PS_W'(1);
   end

   // Out-of-range channel numbers match no channel and are dropped.
   always_comb begin
      ch_we = '0;
      for (int i = 0; i < NUM_CH; i++)
         ch_we[i] = cfg_we && (int'(cfg_ch) == i);
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      timer_channel #(
         .CNT_W          (CNT_W),
         .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .tick        (tick),
         .cfg_we      (ch_we[i]),
         .cfg_period  (cfg_period),
         .cfg_oneshot (cfg_oneshot),
         .start       (start[i]),
         .stop        (stop[i]),
         .pulse       (pulse[i]),
         .busy        (busy[i]),
         .done        (done[i])
      );
   end

endmodule

// File: tb/tb_multi_tick_timer.sv
// tb/tb_multi_tick_timer.sv - self-checking bench for multi_tick_timer
module tb_multi_tick_timer;

   localparam int NCH  = 4;
   localparam int CW   = 32;
   localparam int DEFP = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           cfg_we;
   logic [1:0]     cfg_ch;
   logic [CW-1:0]  cfg_period;
   logic           cfg_oneshot;
   logic [NCH-1:0] start, stop;
   logic [NCH-1:0] pulse, busy, done;
   logic [NCH-1:0] pulse4, busy4, done4;

   int checks = 0;
   int errors = 0;

   multi_tick_timer #(.NUM_CH(NCH), .CNT_W(CW), .PRESCALE(1), .DEFAULT_PERIOD(DEFP)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
      .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
      .pulse(pulse), .busy(busy), .done(done));

   multi_tick_timer #(.NUM_CH(NCH), .CNT_W(CW), .PRESCALE(4), .DEFAULT_PERIOD(DEFP)) dut4 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
      .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
      .pulse(pulse4), .busy(busy4), .done(done4));

   typedef struct {
      logic [NCH-1:0] st, sp;
      logic           we;
      logic [1:0]     ch;
      logic [7:0]     per;
      logic           os;
      logic [NCH-1:0] ep, eb, ed;
   } vec_t;

   vec_t tbl[26];

   function automatic vec_t mk(input logic [3:0] st, input logic [3:0] sp, input logic we,
                               input logic [1:0] ch, input logic [7:0] per, input logic os,
                               input logic [3:0] ep, input logic [3:0] eb, input logic [3:0] ed);
      vec_t v;
      v.st = st; v.sp = sp; v.we = we; v.ch = ch; v.per = per; v.os = os;
      v.ep = ep; v.eb = eb; v.ed = ed;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr();
      cfg_we = 0; cfg_ch = 0; cfg_period = 0; cfg_oneshot = 0; start = 0; stop = 0;
   endtask

   task automatic do_reset();
      clr();
      rst = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic cfg(input int ch, input int per, input logic os);
      cfg_we = 1; cfg_ch = 2'(ch); cfg_period = CW'(per); cfg_oneshot = os;
      @(posedge clk); #1;
      clr();
   endtask

   // Reference model: absolute cycle of each channel's next pulse.
   int          sh_p[NCH];
   bit          sh_os[NCH];
   bit          run[NCH];
   bit          aos[NCH];
   int          due[NCH];
   bit          dn[NCH];
   bit          pl[NCH];

   initial begin
      int pc[3];
      int np;
      logic [NCH-1:0] ep, eb, ed;

      tbl[0]  = mk(4'b0000, 4'b0000, 1, 1, 3, 1, 4'b0000, 4'b0000, 4'b0000);
      tbl[1]  = mk(4'b0010, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000);
      tbl[2]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000);
      tbl[3]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000);
      tbl[4]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0010);
      tbl[5]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0010);
      tbl[6]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0010);
      tbl[7]  = mk(4'b0010, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000);
      tbl[8]  = mk(4'b0000, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[9]  = mk(4'b0010, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000);
      tbl[10] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000);
      tbl[11] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000);
      tbl[12] = mk(4'b0000, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[13] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[14] = mk(4'b0000, 4'b0000, 1, 2, 2, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[15] = mk(4'b0100, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[16] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[17] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[18] = mk(4'b0000, 4'b0000, 1, 3, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[19] = mk(4'b1000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[20] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[21] = mk(4'b1000, 4'b0000, 1, 3, 2, 0, 4'b0000, 4'b0000, 4'b0000);
      tbl[22] = mk(4'b1000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1000, 4'b0000);
      tbl[23] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1000, 4'b0000);
      tbl[24] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b1000, 4'b1000, 4'b0000);
      tbl[25] = mk(4'b0000, 4'b1000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);

      do_reset();
`ifdef AUTO_START_EN
      for (int r = 0; r < 36; r++) begin
         @(negedge clk);
         chk($sformatf("auto_pulse_r%0d", r), pulse, (r > 0 && r % DEFP == 0) ? 4'hF : 4'h0);
         chk($sformatf("auto_busy_r%0d", r), busy, 4'hF);
         @(posedge clk); #1;
      end
`else
      chk("reset_outputs", {pulse, busy, done, pulse4, busy4, done4}, 0);

      // Table: inputs for one cycle, outputs right after that edge.
      for (int k = 0; k < 26; k++) begin
         start = tbl[k].st; stop = tbl[k].sp; cfg_we = tbl[k].we; cfg_ch = tbl[k].ch;
         cfg_period = CW'(tbl[k].per); cfg_oneshot = tbl[k].os;
         @(posedge clk); #1;
         clr();
         chk($sformatf("tbl_row%0d", k), {pulse, busy, done}, {tbl[k].ep, tbl[k].eb, tbl[k].ed});
      end

      // Periodic ch0, period 5, shadow rewritten to 2 and then 0 mid-run.
      do_reset();
      cfg(0, 5, 0);
      for (int r = 0; r < 36; r++) begin
         if (r == 0) start = 4'b0001;
         if (r == 18) begin cfg_we = 1; cfg_ch = 0; cfg_period = 2; end
         if (r == 22) begin cfg_we = 1; cfg_ch = 0; cfg_period = 0; end
         @(negedge clk);
         chk($sformatf("seqA_pulse_r%0d", r), pulse[0], (r inside {6, 11, 16, 21, 23, 25}) ? 1 : 0);
         chk($sformatf("seqA_busy_r%0d", r), busy[0], (r >= 1 && r <= 24) ? 1 : 0);
         @(posedge clk); #1;
         clr();
      end

      // PRESCALE=4 instance, period 3.
      do_reset();
      cfg(0, 3, 0);
      np = 0;
      for (int r = 0; r < 80; r++) begin
         if (r == 0) start = 4'b0001;
         @(negedge clk);
         if (pulse4[0] && np < 3) begin pc[np] = r; np++; end
         @(posedge clk); #1;
         clr();
      end
      chk("seqB_pulse_count", (np >= 3) ? 1 : 0, 1);
      if (np >= 3) begin
         chk("seqB_first_latency_in_range", (pc[0] >= 10 && pc[0] <= 13) ? 1 : 0, 1);
         chk("seqB_spacing1", pc[1] - pc[0], 12);
         chk("seqB_spacing2", pc[2] - pc[1], 12);
      end

      // Reset mid-count, then start with the restored default shadow.
      do_reset();
      cfg(0, 5, 0);
      cfg(1, 2, 1);
      start = 4'b0011;
      @(posedge clk); #1;
      clr();
      repeat (3) begin @(posedge clk); #1; end
      chk("seqC_pre_reset", {busy[1:0], done[1:0]}, 4'b0110);
      rst = 1;
      @(posedge clk); #1;
      chk("seqC_in_reset", {pulse, busy, done}, 0);
      rst = 0;
      for (int r = 0; r < 14; r++) begin
         if (r == 0) start = 4'b0001;
         @(negedge clk);
         chk($sformatf("seqC_pulse_r%0d", r), pulse[0], (r == DEFP + 1) ? 1 : 0);
         @(posedge clk); #1;
         clr();
      end

      // Randomized run against the model.
      do_reset();
      for (int i = 0; i < NCH; i++) begin
         sh_p[i] = DEFP; sh_os[i] = 0; run[i] = 0; aos[i] = 0; due[i] = 0; dn[i] = 0; pl[i] = 0;
      end
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NCH; i++) begin
            ep[i] = pl[i]; eb[i] = run[i]; ed[i] = dn[i];
         end
         chk($sformatf("rand_cycle%0d", n), {pulse, busy, done}, {ep, eb, ed});
         for (int i = 0; i < NCH; i++) begin
            start[i] = ($urandom_range(0, 9) == 0);
            stop[i]  = ($urandom_range(0, 29) == 0);
         end
         cfg_we      = ($urandom_range(0, 4) == 0);
         cfg_ch      = 2'($urandom_range(0, 3));
         cfg_period  = CW'($urandom_range(0, 7));
         cfg_oneshot = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < NCH; i++) begin
            pl[i] = 0;
            if (stop[i]) begin
               run[i] = 0; dn[i] = 0;
            end else if (start[i] && sh_p[i] != 0) begin
               run[i] = 1; aos[i] = sh_os[i]; due[i] = n + sh_p[i] + 1; dn[i] = 0;
            end else if (run[i] && due[i] == n + 1) begin
               pl[i] = 1;
               if (aos[i]) begin
                  run[i] = 0; dn[i] = 1;
               end else if (sh_p[i] == 0) begin
                  run[i] = 0;
               end else begin
                  aos[i] = sh_os[i]; due[i] = n + 1 + sh_p[i];
               end
            end
         end
         if (cfg_we) begin
            sh_p[cfg_ch]  = int'(cfg_period);
            sh_os[cfg_ch] = cfg_oneshot;
         end
         @(posedge clk); #1;
      end
      clr();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
